mcs4_bus_hub: RTL and testbench

MCS4_BUS_HUB -- requirements
Module: mcs4_bus_hub

---
 rtl/mcs4_bus_hub.sv | 236 +++++++++++++++++++++++
 tb/tb_mcs4_bus_hub.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_bus_hub.sv
// -----------------------------------------------------------------------------
// mcs4_bus_hub
//
// Observes the shared 4-bit data bus of an MCS-4 style system. It merges the
// per-device drives into one bus and tracks the eight-subcycle instruction
// cycle from the CPU SYNC pulse. It captures {address, OPR, OPA} from each
// complete cycle into a first-word-fall-through trace FIFO. Protocol
// violations, multiple bus drivers and dropped trace entries are flagged.
//
// Parameters
//   N_DEV  number of devices driving the data bus (1..16)
//   DEPTH  trace FIFO entries (power of two, >= 2)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   clken_2      subcycle strobe; bus sampled / phase advanced only when 1
//   sync         CPU SYNC, asserted during X3
//   dev_dbus     packed device drives, device k at [4k+3:4k]
//   d_bus        combinational OR of all device drives
//   phase        current subcycle A1=0 .. X3=7 (0 while unlocked)
//   in_sync      tracker locked to the instruction cycle
//   trace_valid  FIFO head valid
//   trace_data   FIFO head {addr[11:0], opr[3:0], opa[3:0]}
//   trace_ready  consumer pop request
//   ovf_count    saturating count of dropped trace entries
//   sync_err     sticky SYNC protocol error
//   contention   sticky multi-driver error
//   err_clr      clears sync_err, contention and ovf_count
// -----------------------------------------------------------------------------
module mcs4_bus_hub #(
    parameter int N_DEV = 3,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clken_2,
    input  logic               sync,
    input  logic [4*N_DEV-1:0] dev_dbus,
    output logic [3:0]         d_bus,
    output logic [2:0]         phase,
    output logic               in_sync,
    output logic               trace_valid,
    output logic [19:0]        trace_data,
    input  logic               trace_ready,
    output logic [7:0]         ovf_count,
    output logic               sync_err,
    output logic               contention,
    input  logic               err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Subcycle states share their encoding with the phase output.
    typedef enum logic [3:0] {
        ST_A1     = 4'd0,
        ST_A2     = 4'd1,
        ST_A3     = 4'd2,
        ST_M1     = 4'd3,
        ST_M2     = 4'd4,
        ST_X1     = 4'd5,
        ST_X2     = 4'd6,
        ST_X3     = 4'd7,
        ST_UNSYNC = 4'd8
    } state_t;

    state_t state_q, state_d;

    logic [3:0]  bus_or;
    logic        any_nz;
    logic        multi_drv;
    logic        seq_err;
    logic        abort;
    logic        cap_en;
    logic        push;

    logic [11:0] addr_q;
    logic [3:0]  opr_q;

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    // ------------------------------------------------------------------
    // Wired-OR bus merge and multi-driver detection
    // ------------------------------------------------------------------
    // NOTE: every variable driven here gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        bus_or    = 4'h0;
        any_nz    = 1'b0;
        multi_drv = 1'b0;
        for (int k = 0; k < N_DEV; k++) begin
            if (dev_dbus[4*k +: 4] != 4'h0) begin
                multi_drv = multi_drv | any_nz;
                any_nz    = 1'b1;
            end
            bus_or = bus_or | dev_dbus[4*k +: 4];
        end
    end

    assign d_bus = bus_or;

    // ------------------------------------------------------------------
    // Subcycle tracker: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_UNSYNC;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        seq_err = 1'b0;
        abort   = 1'b0;
        if (clken_2) begin
            case (state_q)
                ST_UNSYNC: begin
                    if (sync) state_d = ST_A1;
                end
                ST_X3: begin
                    if (sync) begin
                        state_d = ST_A1;
                    end else begin
                        state_d = ST_UNSYNC;
                        seq_err = 1'b1;
                    end
                end
                default: begin
                    // SYNC anywhere before X3 means we lost alignment:
                    // resync and throw away the partial capture.
                    if (sync) begin
                        state_d = ST_A1;
                        seq_err = 1'b1;
                        abort   = 1'b1;
                    end else begin
                        state_d = state_t'(state_q + 4'd1);
                    end
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_sync = (state_q != ST_UNSYNC);
        phase   = in_sync ? state_q[2:0] : 3'd0;
        cap_en  = clken_2 && !sync && (state_q <= ST_M2);
        push    = clken_2 && !sync && (state_q == ST_M2);
    end

    // ------------------------------------------------------------------
    // Field capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            addr_q <= 12'h000;
            opr_q  <= 4'h0;
        end else if (cap_en) begin
            case (state_q)
                ST_A1:   addr_q[3:0]  <= bus_or;
                ST_A2:   addr_q[7:4]  <= bus_or;
                ST_A3:   addr_q[11:8] <= bus_or;
                ST_M1:   opr_q        <= bus_or;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Trace FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign full        = (count_q == CW'(DEPTH));
    assign trace_valid = (count_q != '0);
    assign pop         = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok     = push && (!full || pop);
    assign drop        = push && full && !pop;
    assign trace_data  = trace_valid ? mem[rd_ptr] : 20'h0;

    // NOTE: the storage array is not reset; the pointers and count are,
    // and trace_data is masked while empty, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {addr_q, opr_q, bus_or};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags and overflow counter (a set beats err_clr)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err   <= 1'b0;
            contention <= 1'b0;
            ovf_count  <= 8'h00;
        end else begin
            if (seq_err)      sync_err <= 1'b1;
            else if (err_clr) sync_err <= 1'b0;

            if (clken_2 && in_sync && multi_drv) contention <= 1'b1;
            else if (err_clr)                    contention <= 1'b0;

            if (drop) begin
                if (err_clr)                 ovf_count <= 8'd1;
                else if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
            end else if (err_clr) begin
                ovf_count <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_mcs4_bus_hub.sv
// -----------------------------------------------------------------------------
// tb_mcs4_bus_hub
//
// Directed bench for mcs4_bus_hub. The main instance uses the default
// parameters (N_DEV=3, DEPTH=8). Two further instances (N_DEV=1/DEPTH=2 and
// N_DEV=16/DEPTH=16) share the same stimulus and are checked during the
// pointer-wrap scenario.
// -----------------------------------------------------------------------------
module tb_mcs4_bus_hub;

    logic        clk = 1'b0;
    logic        rst;
    logic        clken_2;
    logic        sync;
    logic [11:0] dbus;
    logic        trace_ready;
    logic        err_clr;

    logic [3:0]  d_bus,       d_bus_a,       d_bus_b;
    logic [2:0]  phase,       phase_a,       phase_b;
    logic        in_sync,     in_sync_a,     in_sync_b;
    logic        trace_valid, trace_valid_a, trace_valid_b;
    logic [19:0] trace_data,  trace_data_a,  trace_data_b;
    logic [7:0]  ovf_count,   ovf_count_a,   ovf_count_b;
    logic        sync_err,    sync_err_a,    sync_err_b;
    logic        contention,  contention_a,  contention_b;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    mcs4_bus_hub #(.N_DEV(3), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .clken_2(clken_2), .sync(sync),
        .dev_dbus(dbus), .d_bus(d_bus), .phase(phase), .in_sync(in_sync),
        .trace_valid(trace_valid), .trace_data(trace_data),
        .trace_ready(trace_ready), .ovf_count(ovf_count),
        .sync_err(sync_err), .contention(contention), .err_clr(err_clr)
    );

    mcs4_bus_hub #(.N_DEV(1), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .clken_2(clken_2), .sync(sync),
        .dev_dbus(dbus[3:0]), .d_bus(d_bus_a), .phase(phase_a), .in_sync(in_sync_a),
        .trace_valid(trace_valid_a), .trace_data(trace_data_a),
        .trace_ready(trace_ready), .ovf_count(ovf_count_a),
        .sync_err(sync_err_a), .contention(contention_a), .err_clr(err_clr)
    );

    mcs4_bus_hub #(.N_DEV(16), .DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .clken_2(clken_2), .sync(sync),
        .dev_dbus({52'h0, dbus}), .d_bus(d_bus_b), .phase(phase_b), .in_sync(in_sync_b),
        .trace_valid(trace_valid_b), .trace_data(trace_data_b),
        .trace_ready(trace_ready), .ovf_count(ovf_count_b),
        .sync_err(sync_err_b), .contention(contention_b), .err_clr(err_clr)
    );

    // Trace entry pattern used across scenarios: {addr, opr, opa}.
    function automatic logic [19:0] ent(input int i);
        return {12'(i * 37 + 5), 4'(i), 4'(15 - i)};
    endfunction

    task automatic tick(input logic rdy, input logic clr);
        trace_ready = rdy;
        err_clr     = clr;
        @(posedge clk); #1;
        trace_ready = 1'b0;
        err_clr     = 1'b0;
    endtask

    // One subcycle strobe with the given SYNC, bus drive and handshake inputs.
    task automatic strobe(input logic s, input logic [11:0] bus,
                          input logic rdy, input logic clr);
        clken_2     = 1'b1;
        sync        = s;
        dbus        = bus;
        trace_ready = rdy;
        err_clr     = clr;
        @(posedge clk); #1;
        clken_2     = 1'b0;
        sync        = 1'b0;
        dbus        = 12'h000;
        trace_ready = 1'b0;
        err_clr     = 1'b0;
    endtask

    // Full instruction cycle starting in A1 carrying entry e on device 0.
    task automatic run_cycle(input logic [19:0] e, input logic last_sync,
                             input logic m2_pop, input logic m2_clr);
        strobe(1'b0, {8'h0, e[11:8]},  1'b0, 1'b0);
        strobe(1'b0, {8'h0, e[15:12]}, 1'b0, 1'b0);
        strobe(1'b0, {8'h0, e[19:16]}, 1'b0, 1'b0);
        strobe(1'b0, {8'h0, e[7:4]},   1'b0, 1'b0);
        strobe(1'b0, {8'h0, e[3:0]},   m2_pop, m2_clr);
        strobe(1'b0, 12'h000, 1'b0, 1'b0);
        strobe(1'b0, 12'h000, 1'b0, 1'b0);
        strobe(last_sync, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tests_run++; if (in_sync !== 1'b0) begin fails++; $display("FAIL rst_in_sync: got %b exp 0", in_sync); end
        tests_run++; if (phase !== 3'd0) begin fails++; $display("FAIL rst_phase: got %0d exp 0", phase); end
        tests_run++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", trace_valid); end
        tests_run++; if (trace_data !== 20'h0) begin fails++; $display("FAIL rst_data: got %h exp 0", trace_data); end
        tests_run++; if ({ovf_count, sync_err, contention} !== 10'h0) begin fails++; $display("FAIL rst_errs: got %h exp 0", {ovf_count, sync_err, contention}); end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        logic [3:0] nibs [8];
        nibs = '{4'h3, 4'h2, 4'h1, 4'hA, 4'h5, 4'h0, 4'h0, 4'h0};
        do_reset();
        strobe(1'b1, 12'h000, 1'b0, 1'b0);
        tests_run++; if (in_sync !== 1'b1) begin fails++; $display("FAIL lock_in_sync: got %b exp 1", in_sync); end
        for (int k = 0; k < 8; k++) begin
            tests_run++; if (phase !== 3'(k)) begin fails++; $display("FAIL lock_phase%0d: got %0d exp %0d", k, phase, k); end
            strobe(k == 7, {8'h0, nibs[k]}, 1'b0, 1'b0);
        end
        tests_run++; if (trace_valid !== 1'b1) begin fails++; $display("FAIL lock_valid: got %b exp 1", trace_valid); end
        tests_run++; if (trace_data !== 20'h123A5) begin fails++; $display("FAIL lock_data: got %h exp 123a5", trace_data); end
        tests_run++; if (phase !== 3'd0 || in_sync !== 1'b1) begin fails++; $display("FAIL lock_relock: got phase %0d in_sync %b exp 0/1", phase, in_sync); end
        tests_run++; if (sync_err !== 1'b0) begin fails++; $display("FAIL lock_no_err: got %b exp 0", sync_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        strobe(1'b1, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) run_cycle(ent(i), 1'b1, 1'b0, 1'b0);
        tests_run++; if (ovf_count !== 8'd0) begin fails++; $display("FAIL ovf_full_cnt: got %0d exp 0", ovf_count); end
        tests_run++; if (trace_data !== ent(0)) begin fails++; $display("FAIL ovf_head0: got %h exp %h", trace_data, ent(0)); end
        run_cycle(ent(8), 1'b1, 1'b0, 1'b0);
        run_cycle(ent(9), 1'b1, 1'b0, 1'b0);
        tests_run++; if (ovf_count !== 8'd2) begin fails++; $display("FAIL ovf_two: got %0d exp 2", ovf_count); end
        // drop and err_clr together: count restarts at 1
        run_cycle(ent(10), 1'b1, 1'b0, 1'b1);
        tests_run++; if (ovf_count !== 8'd1) begin fails++; $display("FAIL ovf_clr_race: got %0d exp 1", ovf_count); end
        // push while full with a simultaneous pop: accepted, no overflow
        run_cycle(ent(11), 1'b1, 1'b1, 1'b0);
        tests_run++; if (ovf_count !== 8'd1) begin fails++; $display("FAIL ovf_pushpop: got %0d exp 1", ovf_count); end
        for (int j = 1; j < 8; j++) begin
            tests_run++; if (trace_data !== ent(j)) begin fails++; $display("FAIL ovf_drain%0d: got %h exp %h", j, trace_data, ent(j)); end
            tick(1'b1, 1'b0);
        end
        tests_run++; if (trace_data !== ent(11)) begin fails++; $display("FAIL ovf_drain_last: got %h exp %h", trace_data, ent(11)); end
        tick(1'b1, 1'b0);
        tests_run++; if (trace_valid !== 1'b0 || trace_data !== 20'h0) begin fails++; $display("FAIL ovf_empty: got %b/%h exp 0/0", trace_valid, trace_data); end
        tick(1'b0, 1'b1);
        tests_run++; if (ovf_count !== 8'd0) begin fails++; $display("FAIL ovf_clear: got %0d exp 0", ovf_count); end
    endtask

    task automatic test_sync_error();
        do_reset();
        strobe(1'b1, 12'h000, 1'b0, 1'b0);
        strobe(1'b0, 12'h001, 1'b0, 1'b0);
        strobe(1'b0, 12'h002, 1'b0, 1'b0);
        strobe(1'b0, 12'h003, 1'b0, 1'b0);
        tests_run++; if (phase !== 3'd3) begin fails++; $display("FAIL serr_at_m1: got %0d exp 3", phase); end
        strobe(1'b1, 12'h004, 1'b0, 1'b0);
        tests_run++; if (sync_err !== 1'b1) begin fails++; $display("FAIL serr_set: got %b exp 1", sync_err); end
        tests_run++; if (phase !== 3'd0 || in_sync !== 1'b1) begin fails++; $display("FAIL serr_resync: got phase %0d in_sync %b exp 0/1", phase, in_sync); end
        tests_run++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL serr_no_push: got %b exp 0", trace_valid); end
        run_cycle(ent(20), 1'b0, 1'b0, 1'b0);
        tests_run++; if (in_sync !== 1'b0 || phase !== 3'd0) begin fails++; $display("FAIL serr_x3_miss: got in_sync %b phase %0d exp 0/0", in_sync, phase); end
        tests_run++; if (trace_data !== ent(20)) begin fails++; $display("FAIL serr_entry: got %h exp %h", trace_data, ent(20)); end
        tick(1'b0, 1'b1);
        tests_run++; if (sync_err !== 1'b0) begin fails++; $display("FAIL serr_clear: got %b exp 0", sync_err); end
        strobe(1'b0, 12'h000, 1'b0, 1'b0);
        tests_run++; if (in_sync !== 1'b0) begin fails++; $display("FAIL serr_stay_unsync: got %b exp 0", in_sync); end
        strobe(1'b1, 12'h000, 1'b0, 1'b0);
        tests_run++; if (in_sync !== 1'b1) begin fails++; $display("FAIL serr_relock: got %b exp 1", in_sync); end
        // error event and err_clr in the same cycle: set wins
        strobe(1'b1, 12'h000, 1'b0, 1'b1);
        tests_run++; if (sync_err !== 1'b1) begin fails++; $display("FAIL serr_set_wins: got %b exp 1", sync_err); end
    endtask

    task automatic test_contention();
        do_reset();
        dbus = 12'h401;
        #1;
        tests_run++; if (d_bus !== 4'h5) begin fails++; $display("FAIL cont_dbus: got %h exp 5", d_bus); end
        dbus = 12'h842;
        #1;
        tests_run++; if (d_bus !== 4'hE) begin fails++; $display("FAIL cont_dbus3: got %h exp e", d_bus); end
        strobe(1'b0, 12'h401, 1'b0, 1'b0);
        tests_run++; if (contention !== 1'b0) begin fails++; $display("FAIL cont_unsync: got %b exp 0", contention); end
        strobe(1'b1, 12'h000, 1'b0, 1'b0);
        strobe(1'b0, 12'h004, 1'b0, 1'b0);
        tests_run++; if (contention !== 1'b0) begin fails++; $display("FAIL cont_single: got %b exp 0", contention); end
        strobe(1'b0, 12'h401, 1'b0, 1'b0);
        tests_run++; if (contention !== 1'b1) begin fails++; $display("FAIL cont_set: got %b exp 1", contention); end
        tick(1'b0, 1'b1);
        tests_run++; if (contention !== 1'b0) begin fails++; $display("FAIL cont_clear: got %b exp 0", contention); end
        strobe(1'b0, 12'h0F1, 1'b0, 1'b1);
        tests_run++; if (contention !== 1'b1) begin fails++; $display("FAIL cont_set_wins: got %b exp 1", contention); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        strobe(1'b1, 12'h000, 1'b0, 1'b0);
        for (int i = 30; i < 33; i++) run_cycle(ent(i), 1'b1, 1'b0, 1'b0);
        strobe(1'b0, 12'h011, 1'b0, 1'b0);
        strobe(1'b0, 12'h002, 1'b0, 1'b0);
        tests_run++; if (phase !== 3'd2 || contention !== 1'b1 || trace_valid !== 1'b1) begin fails++; $display("FAIL mrst_pre: got phase %0d cont %b valid %b exp 2/1/1", phase, contention, trace_valid); end
        rst  = 1'b1;
        dbus = 12'h00C;
        tick(1'b0, 1'b0);
        tests_run++; if (d_bus !== 4'hC) begin fails++; $display("FAIL mrst_dbus: got %h exp c", d_bus); end
        tests_run++; if (in_sync !== 1'b0 || phase !== 3'd0) begin fails++; $display("FAIL mrst_tracker: got in_sync %b phase %0d exp 0/0", in_sync, phase); end
        tests_run++; if (trace_valid !== 1'b0 || trace_data !== 20'h0) begin fails++; $display("FAIL mrst_fifo: got %b/%h exp 0/0", trace_valid, trace_data); end
        tests_run++; if ({ovf_count, sync_err, contention} !== 10'h0) begin fails++; $display("FAIL mrst_errs: got %h exp 0", {ovf_count, sync_err, contention}); end
        rst  = 1'b0;
        dbus = 12'h000;
        strobe(1'b0, 12'h000, 1'b0, 1'b0);
        tests_run++; if (in_sync !== 1'b0) begin fails++; $display("FAIL mrst_no_relock: got %b exp 0", in_sync); end
        strobe(1'b1, 12'h000, 1'b0, 1'b0);
        tests_run++; if (in_sync !== 1'b1 || trace_valid !== 1'b0) begin fails++; $display("FAIL mrst_relock: got in_sync %b valid %b exp 1/0", in_sync, trace_valid); end
        run_cycle(ent(33), 1'b1, 1'b0, 1'b0);
        tests_run++; if (trace_data !== ent(33)) begin fails++; $display("FAIL mrst_fresh: got %h exp %h", trace_data, ent(33)); end
    endtask

    task automatic test_wrap_sweep();
        do_reset();
        strobe(1'b1, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 48; i++) begin
            run_cycle(ent(i + 40), 1'b1, 1'b0, 1'b0);
            tests_run++; if (trace_data !== ent(i + 40)) begin fails++; $display("FAIL wrap_d8_%0d: got %h exp %h", i, trace_data, ent(i + 40)); end
            tests_run++; if (trace_data_a !== ent(i + 40)) begin fails++; $display("FAIL wrap_d2_%0d: got %h exp %h", i, trace_data_a, ent(i + 40)); end
            tests_run++; if (trace_data_b !== ent(i + 40)) begin fails++; $display("FAIL wrap_d16_%0d: got %h exp %h", i, trace_data_b, ent(i + 40)); end
            tick(1'b1, 1'b0);
        end
        tests_run++; if ({trace_valid, trace_valid_a, trace_valid_b} !== 3'b000) begin fails++; $display("FAIL wrap_empty: got %b exp 000", {trace_valid, trace_valid_a, trace_valid_b}); end
        for (int i = 0; i < 3; i++) run_cycle(ent(i + 100), 1'b1, 1'b0, 1'b0);
        tests_run++; if (ovf_count_a !== 8'd1) begin fails++; $display("FAIL wrap_d2_ovf: got %0d exp 1", ovf_count_a); end
        tests_run++; if (ovf_count_b !== 8'd0 || ovf_count !== 8'd0) begin fails++; $display("FAIL wrap_big_ovf: got %0d/%0d exp 0/0", ovf_count_b, ovf_count); end
        tests_run++; if (trace_data_a !== ent(100)) begin fails++; $display("FAIL wrap_d2_head: got %h exp %h", trace_data_a, ent(100)); end
        tick(1'b1, 1'b0);
        tests_run++; if (trace_data_a !== ent(101)) begin fails++; $display("FAIL wrap_d2_second: got %h exp %h", trace_data_a, ent(101)); end
    endtask

    initial begin
        rst         = 1'b1;
        clken_2     = 1'b0;
        sync        = 1'b0;
        dbus        = 12'h000;
        trace_ready = 1'b0;
        err_clr     = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_lock();
        test_overflow();
        test_sync_error();
        test_contention();
        test_mid_reset();
        test_wrap_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
